segment_sequencer: RTL and testbench
====================================

Name: segment_sequencer

Overview:
- Sequences waveform segments on the synthesis clock domain.
- Holds a queue of host-written segment durations and counts each segment down.
- Commands the parameter bank swap (staged amps/offsets/phasewords to active) and the oscillator-bank reset at each boundary.
- Gates sample writes into the output FIFO and pulses a finished event when the queue drains. Sits between the host endpoints and the 64-oscillator datapath.

Parameters:
- DEPTH, 16, duration queue entries (power of two, >=2).
- DUR_W, 16, duration width in clk cycles.
- IDX_W, 6, segment index width (wraps).

Ports:
- clk  in  1  synthesis clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high; clears all state, queue and flags.
- start  in  1  one-cycle pulse: begin sequence.
- abort  in  1  one-cycle pulse: stop and flush.
- dur_data  in  DUR_W  segment duration.
- dur_write  in  1  push dur_data into queue.
- bank_ready  in  1  pulse: staged parameter bank fully loaded.
- swap  out  1  one-cycle pulse: copy staged bank to active.
- block_reset  out  1  oscillator-bank reset, high exactly with swap.
- sample_en  out  1  output-FIFO write enable.
- time_left  out  DUR_W  remaining samples in current segment.
- seg_index  out  IDX_W  index of current segment.
- busy  out  1  high in any state except IDLE.
- finished  out  1  one-cycle pulse at sequence end.
- underrun  out  1  sticky: boundary reached with bank not ready.
- overflow  out  1  sticky: write attempted while queue full.
- queue_count  out  $clog2(DEPTH)+1  entries held.

Behaviour:
- Reset values: all outputs 0; state IDLE; bank_pending 0; queue empty; seg_index 0.
- Queue:
  - Synchronous FIFO. Push when dur_write && count<DEPTH.
  - A push while full is dropped and sets overflow.
  - Push and pop in the same cycle is legal; count is unchanged.
- bank_pending: set by bank_ready, cleared in SWAP. A bank_ready in the SWAP cycle itself wins and leaves bank_pending set.
- Outputs swap, block_reset, sample_en, busy and finished are Moore, decoded from registered state.
- IDLE:
  - On start with queue nonempty: go to SWAP if bank_pending or bank_ready, else go to WAIT and set underrun.
  - On start with queue empty: start is ignored and sets underrun.
  - A start clears underrun in the same cycle before the above evaluation.
- SWAP (exactly 1 cycle):
  - swap=1, block_reset=1.
  - Pop the queue head into time_left.
  - seg_index <= 0 on the first swap after IDLE, else seg_index+1 (wraps).
  - Next state: RUN.
- RUN:
  - sample_en = (time_left!=0); time_left decrements while nonzero. sample_en is high for exactly D cycles; D=0 yields no samples.
  - Boundary is the cycle with time_left<=1.
  - At boundary: queue empty -> DONE; queue nonempty and (bank_pending or bank_ready) -> SWAP; otherwise -> WAIT and set underrun.
  - Back-to-back segments therefore have a 1-cycle sample_en gap (the SWAP cycle).
- WAIT: sample_en=0, time_left=0. On bank_pending or bank_ready -> SWAP.
- DONE: finished=1 for 1 cycle, then IDLE.
- Latency: start sampled in cycle N -> swap in N+1 -> first sample_en in N+2.
- abort:
  - Highest priority after reset, from any state.
  - Next state IDLE; queue flushed; bank_pending, time_left and overflow cleared; underrun is held.
  - No finished pulse.
  - abort and start in the same cycle: abort wins.
- start while busy: ignored.
- dur_write during RUN is legal and extends the sequence.

Decomposition:
- Package segment_seq_pkg: state enum (IDLE, SWAP, RUN, WAIT, DONE), default DEPTH/DUR_W/IDX_W constants.
- One sub-module: dur_fifo (single-clock synchronous FIFO with count, full, empty, flush input).

Test Plan:
- Push durations 3,2; bank_ready; start at cycle N:
  - swap at N+1, sample_en N+2..N+4.
  - WAIT from N+5 with underrun=1.
  - bank_ready at N+7 -> swap at N+8, sample_en N+9..N+10, finished at N+11, busy=0 at N+12.
- Push 2,2; bank_ready before start and again during segment 0:
  - sample_en N+2..N+3, swap N+4, sample_en N+5..N+6, seg_index 0 then 1.
  - underrun stays 0.
- Push duration 0; bank_ready; start -> swap N+1, no sample_en, finished N+3.
- Start with empty queue -> state stays IDLE, underrun=1, no swap. A later valid start clears underrun.
- Push 17 entries with DEPTH=16 -> queue_count=16, overflow=1.
- Start, then abort mid-RUN -> IDLE next cycle, sample_en=0, queue_count=0, overflow=0, no finished.
- Abort and start in the same cycle -> stays IDLE, no swap.

Source files
------------

// File: rtl/segment_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module : segment_seq_pkg
// Brief  : Shared state encoding and default sizing for the segment sequencer.
// Rev    : 1.0  initial release
// ============================================================================
package segment_seq_pkg;

    localparam int c_depth_default = 16;
    localparam int c_dur_w_default = 16;
    localparam int c_idx_w_default = 6;

    localparam int c_state_w = 3;
    typedef logic [c_state_w-1:0] state_t;

    localparam logic [2:0] c_st_idle = 3'd0;
    localparam logic [2:0] c_st_swap = 3'd1;
    localparam logic [2:0] c_st_run  = 3'd2;
    localparam logic [2:0] c_st_wait = 3'd3;
    localparam logic [2:0] c_st_done = 3'd4;

endpackage
`default_nettype wire

// File: rtl/dur_fifo.sv
`default_nettype none
// ============================================================================
// Module : dur_fifo
// Brief  : Single-clock synchronous FIFO with occupancy count and flush.
// Rev    : 1.0  initial release
// ============================================================================
module dur_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int              c_aw         = $clog2(DEPTH);
    localparam logic [c_aw:0]   c_full_count = DEPTH[c_aw:0];

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_aw:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == c_full_count);
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_data    = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_aw'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_aw'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (c_aw+1)'(1);
                2'b01:   r_count <= r_count - (c_aw+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/segment_sequencer.sv
`default_nettype none
// ============================================================================
// Module : segment_sequencer
// Brief  : Counts queued segment durations, commands bank swaps and gates
//          sample writes on the synthesis clock.
// Rev    : 1.0  initial release
// ============================================================================
module segment_sequencer
    import segment_seq_pkg::*;
#(
    parameter int DEPTH = c_depth_default,
    parameter int DUR_W = c_dur_w_default,
    parameter int IDX_W = c_idx_w_default
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     abort,
    input  logic [DUR_W-1:0]         dur_data,
    input  logic                     dur_write,
    input  logic                     bank_ready,
    output logic                     swap,
    output logic                     block_reset,
    output logic                     sample_en,
    output logic [DUR_W-1:0]         time_left,
    output logic [IDX_W-1:0]         seg_index,
    output logic                     busy,
    output logic                     finished,
    output logic                     underrun,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   queue_count
);

    state_t           r_state;
    logic             r_bank_pending;
    logic             r_first;
    logic             r_underrun;
    logic             r_overflow;
    logic [DUR_W-1:0] r_time_left;
    logic [IDX_W-1:0] r_seg_index;

    logic             w_pop;
    logic             w_q_empty;
    logic             w_q_full;
    logic [DUR_W-1:0] w_q_head;
    logic             w_bank_ok;

    assign w_pop     = (r_state == c_st_swap);
    assign w_bank_ok = r_bank_pending || bank_ready;

    dur_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DUR_W)
    ) u_dur_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_flush (abort),
        .i_push  (dur_write),
        .i_data  (dur_data),
        .i_pop   (w_pop),
        .o_data  (w_q_head),
        .o_count (queue_count),
        .o_full  (w_q_full),
        .o_empty (w_q_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= c_st_idle;
            r_bank_pending <= 1'b0;
            r_first        <= 1'b1;
            r_underrun     <= 1'b0;
            r_overflow     <= 1'b0;
            r_time_left    <= '0;
            r_seg_index    <= '0;
        end else if (abort) begin
            // Underrun is deliberately kept so the host can still see it.
            r_state        <= c_st_idle;
            r_bank_pending <= 1'b0;
            r_first        <= 1'b1;
            r_overflow     <= 1'b0;
            r_time_left    <= '0;
        end else begin
            if (dur_write && w_q_full) begin
                r_overflow <= 1'b1;
            end
            if (bank_ready) begin
                r_bank_pending <= 1'b1;
            end else if (r_state == c_st_swap) begin
                r_bank_pending <= 1'b0;
            end

            case (r_state)
                c_st_idle: begin
                    r_first <= 1'b1;
                    if (start) begin
                        r_underrun <= w_q_empty || !w_bank_ok;
                        if (!w_q_empty) begin
                            r_state <= w_bank_ok ? c_st_swap : c_st_wait;
                        end
                    end
                end
                c_st_swap: begin
                    r_time_left <= w_q_head;
                    r_seg_index <= r_first ? '0 : r_seg_index + IDX_W'(1);
                    r_first     <= 1'b0;
                    r_state     <= c_st_run;
                end
                c_st_run: begin
                    if (r_time_left != '0) begin
                        r_time_left <= r_time_left - DUR_W'(1);
                    end
                    if (r_time_left <= DUR_W'(1)) begin
                        if (w_q_empty) begin
                            r_state <= c_st_done;
                        end else if (w_bank_ok) begin
                            r_state <= c_st_swap;
                        end else begin
                            r_state    <= c_st_wait;
                            r_underrun <= 1'b1;
                        end
                    end
                end
                c_st_wait: begin
                    r_time_left <= '0;
                    if (w_bank_ok) begin
                        r_state <= c_st_swap;
                    end
                end
                c_st_done: begin
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign swap        = (r_state == c_st_swap);
    assign block_reset = (r_state == c_st_swap);
    assign sample_en   = (r_state == c_st_run) && (r_time_left != '0);
    assign busy        = (r_state != c_st_idle);
    assign finished    = (r_state == c_st_done);
    assign time_left   = r_time_left;
    assign seg_index   = r_seg_index;
    assign underrun    = r_underrun;
    assign overflow    = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_segment_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_segment_sequencer
// Brief  : Directed scenarios plus randomized sequences against an
//          event-time model of segment boundaries.
// Rev    : 1.0  initial release
// ============================================================================
module tb_segment_sequencer;

    localparam int c_l = 120;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] dur_data = '0;
    logic        dur_write = 1'b0;
    logic        bank_ready = 1'b0;
    logic        swap, block_reset, sample_en, busy, finished, underrun, overflow;
    logic [15:0] time_left;
    logic [5:0]  seg_index;
    logic [4:0]  queue_count;

    int n_checks = 0;
    int n_errors = 0;

    segment_sequencer u_dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .dur_data    (dur_data),
        .dur_write   (dur_write),
        .bank_ready  (bank_ready),
        .swap        (swap),
        .block_reset (block_reset),
        .sample_en   (sample_en),
        .time_left   (time_left),
        .seg_index   (seg_index),
        .busy        (busy),
        .finished    (finished),
        .underrun    (underrun),
        .overflow    (overflow),
        .queue_count (queue_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance into the next cycle; inputs default low, outputs are settled.
    task automatic next_cycle();
        @(posedge clk);
        #1;
        reset = 1'b0; start = 1'b0; abort = 1'b0;
        dur_write = 1'b0; bank_ready = 1'b0;
    endtask

    task automatic do_reset();
        next_cycle(); reset = 1'b1;
        next_cycle(); reset = 1'b1;
        next_cycle();
    endtask

    task automatic push(input int v);
        next_cycle();
        dur_data  = 16'(v);
        dur_write = 1'b1;
    endtask

    // Bit i of each mask describes the cycle i+1 after the start cycle.
    task automatic trace(input string tag, input int len, input logic [15:0] swp,
                         input logic [15:0] sen, input logic [15:0] fin,
                         input logic [15:0] bsy, input logic [15:0] brm);
        for (int i = 0; i < len; i++) begin
            next_cycle();
            bank_ready = brm[i];
            chk({tag, "_swap"}, 32'(swap), 32'(swp[i]));
            chk({tag, "_blkrst"}, 32'(block_reset), 32'(swp[i]));
            chk({tag, "_sample_en"}, 32'(sample_en), 32'(sen[i]));
            chk({tag, "_finished"}, 32'(finished), 32'(fin[i]));
            chk({tag, "_busy"}, 32'(busy), 32'(bsy[i]));
        end
    endtask

    int  dur [8];
    int  s   [8];
    int  bnd [8];
    int  ucyc[8];
    bit  br  [c_l];
    int  n, nu, done_c, lo, hi, t, m, e_tl, e_sen, e_swp, e_und;
    bit  found;

    initial begin
        // Reset state
        do_reset();
        chk("rst_swap", 32'(swap), 0);
        chk("rst_sample_en", 32'(sample_en), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_finished", 32'(finished), 0);
        chk("rst_underrun", 32'(underrun), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_time_left", 32'(time_left), 0);
        chk("rst_seg_index", 32'(seg_index), 0);
        chk("rst_count", 32'(queue_count), 0);

        // Durations 3,2 with a late second bank
        push(3); push(2);
        next_cycle(); bank_ready = 1'b1;
        next_cycle(); start = 1'b1;
        trace("seq32", 12, 16'h0081, 16'h030E, 16'h0400, 16'h07FF, 16'h0040);
        chk("seq32_underrun", 32'(underrun), 1);

        // Durations 2,2 with the second bank ready in time
        do_reset();
        push(2); push(2);
        next_cycle(); bank_ready = 1'b1;
        next_cycle(); start = 1'b1;
        trace("seq22", 8, 16'h0009, 16'h0036, 16'h0040, 16'h007F, 16'h0002);
        chk("seq22_underrun", 32'(underrun), 0);
        chk("seq22_seg_index", 32'(seg_index), 1);

        // Zero-length segment
        do_reset();
        push(0);
        next_cycle(); bank_ready = 1'b1;
        next_cycle(); start = 1'b1;
        trace("zero", 4, 16'h0001, 16'h0000, 16'h0004, 16'h0007, 16'h0000);

        // Start with an empty queue, then a valid start
        do_reset();
        next_cycle(); start = 1'b1;
        trace("empty", 3, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        chk("empty_underrun", 32'(underrun), 1);
        push(1);
        next_cycle(); bank_ready = 1'b1;
        next_cycle(); start = 1'b1;
        next_cycle();
        chk("restart_underrun", 32'(underrun), 0);
        chk("restart_swap", 32'(swap), 1);

        // Overflow on the 17th push, then abort mid-run
        do_reset();
        for (int i = 0; i < 16; i++) push(5);
        next_cycle();
        chk("full_count", 32'(queue_count), 16);
        chk("full_overflow", 32'(overflow), 0);
        dur_data = 16'd5; dur_write = 1'b1;
        next_cycle();
        chk("ovf_count", 32'(queue_count), 16);
        chk("ovf_overflow", 32'(overflow), 1);
        bank_ready = 1'b1;
        next_cycle(); start = 1'b1;
        next_cycle();
        chk("abort_pre_swap", 32'(swap), 1);
        next_cycle();
        next_cycle();
        chk("abort_pre_sample_en", 32'(sample_en), 1);
        abort = 1'b1;
        next_cycle();
        chk("abort_busy", 32'(busy), 0);
        chk("abort_sample_en", 32'(sample_en), 0);
        chk("abort_count", 32'(queue_count), 0);
        chk("abort_overflow", 32'(overflow), 0);
        chk("abort_time_left", 32'(time_left), 0);
        for (int i = 0; i < 3; i++) begin
            chk("abort_finished", 32'(finished), 0);
            next_cycle();
        end

        // Abort and start together
        do_reset();
        push(1);
        next_cycle(); bank_ready = 1'b1;
        next_cycle(); start = 1'b1; abort = 1'b1;
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            chk("abst_swap", 32'(swap), 0);
            chk("abst_busy", 32'(busy), 0);
            chk("abst_count", 32'(queue_count), 0);
        end

        // Randomized sequences against an event-time model
        for (int sc = 0; sc < 20; sc++) begin
            n = 1 + int'($urandom_range(5));
            for (int k = 0; k < n; k++) dur[k] = int'($urandom_range(5));
            br[0] = 1'($urandom_range(1));
            for (int r = 1; r < c_l; r++) br[r] = (r % 8 == 0) || ($urandom_range(3) == 0);

            // Segment k swaps in s[k]; its boundary is s[k]+max(D,1). The next
            // swap follows at once if a bank arrived in [s[k], boundary].
            nu = 0; lo = 0; hi = 0;
            for (int k = 0; k < n; k++) begin
                found = 1'b0;
                for (int r = lo; r <= hi; r++) if (br[r]) found = 1'b1;
                if (found) begin
                    s[k] = hi + 1;
                end else begin
                    ucyc[nu] = hi; nu++;
                    t = hi + 1;
                    while (t < c_l - 1 && !br[t]) t++;
                    s[k] = t + 1;
                end
                bnd[k] = s[k] + ((dur[k] > 0) ? dur[k] : 1);
                lo = s[k]; hi = bnd[k];
            end
            done_c = bnd[n-1] + 1;

            do_reset();
            for (int k = 0; k < n; k++) push(dur[k]);
            for (int r = 0; r < c_l; r++) begin
                next_cycle();
                start = (r == 0);
                bank_ready = br[r];
                e_swp = 0; e_sen = 0; e_tl = 0; m = 0; e_und = 0;
                for (int k = 0; k < n; k++) begin
                    if (s[k] == r) e_swp = 1;
                    if (s[k] < r) m++;
                    if (r >= s[k] + 1 && r <= s[k] + dur[k]) e_sen = 1;
                    if (r >= s[k] + 1 && r <= bnd[k]) e_tl = dur[k] - (r - s[k] - 1);
                end
                for (int j = 0; j < nu; j++) if (ucyc[j] < r) e_und = 1;
                chk("rnd_swap", 32'(swap), 32'(e_swp));
                chk("rnd_sample_en", 32'(sample_en), 32'(e_sen));
                chk("rnd_time_left", 32'(time_left), 32'(e_tl));
                chk("rnd_finished", 32'(finished), 32'(r == done_c));
                chk("rnd_busy", 32'(busy), 32'(r >= 1 && r <= done_c));
                chk("rnd_count", 32'(queue_count), 32'(n - m));
                chk("rnd_seg_index", 32'(seg_index), 32'((m == 0) ? 0 : (m - 1) % 64));
                chk("rnd_underrun", 32'(underrun), 32'(e_und));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
